apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 11 +
 rtl/apb_wait_timer.sv | 24 ++
 rtl/apb_master.sv | 118 +++++++++++
 tb/tb_apb_master.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type and APB data/strobe widths for apb_master
package apb_pkg;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;
endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts stalled ACCESS cycles and flags when the limit is reached
module apb_wait_timer #(
    parameter int TimeoutCycles = 16
) (
    input  logic p_clk,
    input  logic p_resetn,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TimeoutCycles + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // cnt_q holds stalled cycles already seen, so this cycle is the limit when it is one short
    assign expired = en && (cnt_q == CW'(TimeoutCycles - 1));
    // next count: restart for each transfer, advance on every stalled cycle
    always_comb begin
        cnt_d = clear ? '0 : en ? cnt_q + CW'(1) : cnt_q;
    end
    // counter register
    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) cnt_q <= '0;
        else           cnt_q <= cnt_d;
    end
endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding request/response to APB master bridge
// Optional macro APB_MASTER_TIMEOUT_EN bounds the ACCESS wait to TimeoutCycles.
module apb_master
    import apb_pkg::*;
#(
    parameter int AddrBits      = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                  p_clk,
    input  logic                  p_resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [AddrBits-1:0]   req_addr,
    input  logic [APB_DATA_W-1:0] req_wdata,
    input  logic [APB_STRB_W-1:0] req_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [AddrBits-1:0]   p_addr,
    output logic                  p_sel,
    output logic                  p_enable,
    output logic                  p_write,
    output logic [APB_DATA_W-1:0] p_wdata,
    output logic [APB_STRB_W-1:0] p_strb,
    input  logic [APB_DATA_W-1:0] p_rdata,
    input  logic                  p_ready,
    input  logic                  p_slverr
);
    apb_state_e            state_q, state_d;
    logic [AddrBits-1:0]   addr_q, addr_d;
    logic                  write_q, write_d;
    logic [APB_DATA_W-1:0] wdata_q, wdata_d;
    logic [APB_STRB_W-1:0] strb_q, strb_d;
    logic [APB_DATA_W-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  xfer;
    logic                  timeout;

`ifdef APB_MASTER_TIMEOUT_EN
    apb_wait_timer #(.TimeoutCycles(TimeoutCycles)) u_wait_timer (
        .p_clk   (p_clk),
        .p_resetn(p_resetn),
        .clear   (state_q == SETUP),
        .en      (state_q == ACCESS && !p_ready),
        .expired (timeout)
    );
`else
    localparam int unused_timeout_cycles = TimeoutCycles;
    assign timeout = 1'b0;
`endif

    assign xfer      = (state_q == SETUP) || (state_q == ACCESS);
    assign req_ready = p_resetn && (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid && err_q;
    assign p_sel     = xfer;
    assign p_enable  = (state_q == ACCESS);
    assign p_addr    = xfer ? addr_q : '0;
    assign p_write   = xfer && write_q;
    assign p_wdata   = xfer ? wdata_q : '0;
    assign p_strb    = xfer ? strb_q : '0;

    // FSM transitions, request capture (reads store zero data/strobe) and response capture
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = SETUP;
                addr_d  = req_addr;
                write_d = req_write;
                wdata_d = req_write ? req_wdata : '0;
                strb_d  = req_write ? req_strb : '0;
            end
            SETUP: state_d = ACCESS;
            ACCESS: if (p_ready) begin
                state_d = RESP;
                err_d   = p_slverr;
                rdata_d = write_q ? '0 : p_rdata;
            end else if (timeout) begin
                state_d = RESP;
                err_d   = 1'b1;
                rdata_d = '0;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and captured request/response registers; reset discards any transfer in flight
    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed-vector bench for apb_master (timeout path when APB_MASTER_TIMEOUT_EN is defined)
module tb_apb_master;
    logic        p_clk = 1'b0;
    logic        p_resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] p_addr;
    logic        p_sel;
    logic        p_enable;
    logic        p_write;
    logic [31:0] p_wdata;
    logic [3:0]  p_strb;
    logic [31:0] p_rdata = '0;
    logic        p_ready = 1'b0;
    logic        p_slverr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    apb_master #(.AddrBits(32), .TimeoutCycles(4)) dut (
        .p_clk(p_clk), .p_resetn(p_resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .p_addr(p_addr), .p_sel(p_sel), .p_enable(p_enable), .p_write(p_write),
        .p_wdata(p_wdata), .p_strb(p_strb), .p_rdata(p_rdata), .p_ready(p_ready),
        .p_slverr(p_slverr)
    );

    always #5 p_clk = ~p_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge p_clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        req_strb  = st;
        step();
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    // APB slave: inserts 'waits' stall cycles, drives slverr=1 while stalled, records bus values
    task automatic slave(input int waits, input logic [31:0] rd, input logic err,
                         output int sc, output int ec, output logic [31:0] a_s,
                         output logic [31:0] w_s, output logic [3:0] s_s, output logic stab);
        sc = 0; ec = 0; stab = 1'b1; a_s = '0; w_s = '0; s_s = '0;
        for (int i = 0; i < 200 && !rsp_valid; i++) begin
            if (p_sel) begin
                if (sc == 0) begin
                    a_s = p_addr; w_s = p_wdata; s_s = p_strb;
                end else if (p_addr !== a_s || p_wdata !== w_s || p_strb !== s_s) begin
                    stab = 1'b0;
                end
                sc++;
            end
            if (p_enable) ec++;
            p_ready  = p_enable && (ec == waits + 1);
            p_rdata  = p_ready ? rd : 32'h1111_1111;
            p_slverr = p_ready ? err : 1'b1;
            step();
        end
        p_ready = 1'b0;
        p_slverr = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    int sc, ec;
    logic [31:0] a_s, w_s;
    logic [3:0] s_s;
    logic stab, ok;

    initial begin
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_p_sel", p_sel, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        step(); step();
        p_resetn = 1'b1;
        step();
        check("post_rst_req_ready", req_ready, 1);
        check("post_rst_p_addr", p_addr, 0);

        // write with two wait states
        issue(1'b1, 32'h08, 32'hA5A5_1234, 4'b0011);
        check("wr_p_write", p_write, 1);
        slave(2, 32'hFFFF_FFFF, 1'b0, sc, ec, a_s, w_s, s_s, stab);
        check("wr_sel_cycles", sc, 4);
        check("wr_en_cycles", ec, 3);
        check("wr_p_strb", s_s, 4'b0011);
        check("wr_p_addr", a_s, 32'h08);
        check("wr_p_wdata", w_s, 32'hA5A5_1234);
        check("wr_stable", stab, 1);
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_rsp_rdata", rsp_rdata, 0);
        check("wr_resp_p_sel", p_sel, 0);
        check("wr_resp_req_ready", req_ready, 0);
        handshake();
        check("wr_idle_rsp_valid", rsp_valid, 0);
        check("wr_idle_req_ready", req_ready, 1);

        // read, zero wait states, slave error
        issue(1'b0, 32'h10, 32'hFFFF_FFFF, 4'hF);
        check("rd_p_write", p_write, 0);
        slave(0, 32'hDEAD_BEEF, 1'b1, sc, ec, a_s, w_s, s_s, stab);
        check("rd_sel_cycles", sc, 2);
        check("rd_en_cycles", ec, 1);
        check("rd_p_strb", s_s, 4'b0000);
        check("rd_p_wdata", w_s, 0);
        check("rd_p_addr", a_s, 32'h10);
        check("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("rd_rsp_err", rsp_err, 1);
        handshake();

        // write with all strobes clear still transfers
        issue(1'b1, 32'h20, 32'h0000_0001, 4'b0000);
        slave(1, 32'h0, 1'b0, sc, ec, a_s, w_s, s_s, stab);
        check("zs_sel_cycles", sc, 3);
        check("zs_en_cycles", ec, 2);
        check("zs_p_strb", s_s, 4'b0000);
        check("zs_p_wdata", w_s, 32'h1);
        check("zs_rsp_err", rsp_err, 0);
        handshake();

        // response backpressure with a second request pending
        issue(1'b1, 32'h30, 32'h5, 4'hF);
        slave(0, 32'h0, 1'b0, sc, ec, a_s, w_s, s_s, stab);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h34;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!rsp_valid || req_ready || p_sel) ok = 1'b0;
            step();
        end
        check("bp_hold", ok, 1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp_release_req_ready", req_ready, 1);
        check("bp_release_p_sel", p_sel, 0);
        check("bp_release_rsp_valid", rsp_valid, 0);
        step();
        req_valid = 1'b0;
        check("bp_second_setup", p_sel, 1);
        check("bp_second_addr", p_addr, 32'h34);
        slave(0, 32'h0000_00AB, 1'b0, sc, ec, a_s, w_s, s_s, stab);
        check("bp_second_rdata", rsp_rdata, 32'hAB);
        handshake();

        // reset in ACCESS
        issue(1'b0, 32'h40, 32'h0, 4'h0);
        step();
        check("rs_in_access", p_enable, 1);
        p_resetn = 1'b0;
        #1;
        check("rs_p_sel", p_sel, 0);
        check("rs_p_enable", p_enable, 0);
        step(); step();
        p_resetn = 1'b1;
        step();
        check("rs_idle_req_ready", req_ready, 1);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid || p_sel) ok = 1'b0;
            step();
        end
        check("rs_no_rsp", ok, 1);

`ifdef APB_MASTER_TIMEOUT_EN
        // slave never ready: timeout after 4 ACCESS cycles
        issue(1'b0, 32'h50, 32'h0, 4'h0);
        slave(1000, 32'h0, 1'b0, sc, ec, a_s, w_s, s_s, stab);
        check("to_en_cycles", ec, 4);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        handshake();
        // ready on the timeout cycle wins
        issue(1'b0, 32'h54, 32'h0, 4'h0);
        slave(3, 32'h1234_5678, 1'b0, sc, ec, a_s, w_s, s_s, stab);
        check("tp_en_cycles", ec, 4);
        check("tp_rsp_err", rsp_err, 0);
        check("tp_rsp_rdata", rsp_rdata, 32'h1234_5678);
        handshake();
`else
        // slave never ready: waits indefinitely
        issue(1'b0, 32'h50, 32'h0, 4'h0);
        p_slverr = 1'b1;
        for (int i = 0; i < 100; i++) step();
        check("nt_p_enable", p_enable, 1);
        check("nt_p_sel", p_sel, 1);
        check("nt_rsp_valid", rsp_valid, 0);
        slave(0, 32'h0000_0077, 1'b0, sc, ec, a_s, w_s, s_s, stab);
        check("nt_rsp_rdata", rsp_rdata, 32'h77);
        check("nt_rsp_err", rsp_err, 0);
        handshake();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
